bridge_split: RTL

Width-splitting stage that sits directly downstream of the element-combining bridge in the zero-skip datapath. Accepts one wide word of DIN_W elements per handshake and emits it as SPLIT_N consecutive narrow slices of DOUT_W elements, oldest slice first. The word's last flag is carried on its final emitted slice. A compile-time option drops all-zero slices, so the consumer sees only non-zero payload.

---
 rtl/bridge_split_pkg.sv | 13 +
 rtl/bridge_split_if.sv | 20 ++
 rtl/bridge_split_pick.sv | 36 +++
 rtl/bridge_split.sv | 98 +++++++++
 4 files changed

// File: rtl/bridge_split_pkg.sv
// Shared definitions for the element-combining and width-splitting bridges:
// the handshake state and the emission-order mapping.
package bridge_pkg;

  typedef enum logic {Empty, Split} state_t;

  // Maps an emission position to a segment index. The mapping is its own
  // inverse, so it also maps a segment back to its emission position.
  function automatic int seg_of_pos(input int pos, input int n, input bit big_en);
    return big_en ? pos : (n - 1 - pos);
  endfunction

endpackage

// File: rtl/bridge_split_if.sv
// Handshake bundle of bridge_split: wide words in, narrow slices out.
interface bridge_split_if #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 8,
  parameter int DATA_W = 8
);
  logic                           vld_i;
  logic [DIN_W-1:0][DATA_W-1:0]   din;
  logic                           last_i;
  logic                           rdy_o;
  logic                           vld_o;
  logic [DOUT_W-1:0][DATA_W-1:0]  dout;
  logic                           last_o;
  logic                           rdy_i;

  modport slave  (input  vld_i, din, last_i, rdy_i,
                  output rdy_o, vld_o, dout, last_o);
  modport master (output vld_i, din, last_i, rdy_i,
                  input  rdy_o, vld_o, dout, last_o);
endinterface

// File: rtl/bridge_split_pick.sv
// Order-aware priority selector over the pending-slice mask: first pending
// segment of a fresh mask, next pending segment after cur, and final flag.
module bridge_split_pick import bridge_pkg::*; #(
  parameter int SPLIT_N = 4,
  parameter int BIG_EN  = 1,
  parameter int IDX_W   = $clog2(SPLIT_N)
) (
  input  logic [SPLIT_N-1:0] cap_mask,
  input  logic [SPLIT_N-1:0] pend,
  input  logic [IDX_W-1:0]   cur,
  output logic [IDX_W-1:0]   first_idx,
  output logic [IDX_W-1:0]   next_idx,
  output logic               is_final
);

  int               cur_pos;
  logic [IDX_W-1:0] seg_v;

  // Walk positions from last to first so the earliest pending position wins.
  always_comb begin
    first_idx = '0;
    next_idx  = cur;
    is_final  = 1'b1;
    seg_v     = '0;
    cur_pos   = seg_of_pos(int'(cur), SPLIT_N, BIG_EN != 0);
    for (int p = SPLIT_N - 1; p >= 0; p--) begin
      seg_v = IDX_W'(seg_of_pos(p, SPLIT_N, BIG_EN != 0));
      if (cap_mask[seg_v]) first_idx = seg_v;
      if ((p > cur_pos) && pend[seg_v]) begin
        next_idx = seg_v;
        is_final = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bridge_split.sv
// Splits one DIN_W-element word into SPLIT_N DOUT_W-element slices.
// Define BRIDGE_SPLIT_ZSKIP_EN to drop all-zero slices.
module bridge_split import bridge_pkg::*; #(
  parameter int DIN_W   = 32,
  parameter int DOUT_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SPLIT_N = DIN_W / DOUT_W,
  parameter int BIG_EN  = 1
) (
  input logic           clk,
  input logic           rst,
  bridge_split_if.slave bus
);

  localparam int IDX_W = $clog2(SPLIT_N);

  typedef logic [SPLIT_N-1:0][DOUT_W-1:0][DATA_W-1:0] word_t;

  state_t             state_q, state_d;
  word_t              word_q, din_w;
  logic               last_q;
  logic [SPLIT_N-1:0] pend_q, cap_mask;
  logic [IDX_W-1:0]   idx_q, first_idx, next_idx;
  logic               is_final, accept, capture, absorb, load;

  assign din_w = bus.din;

`ifdef BRIDGE_SPLIT_ZSKIP_EN
  localparam int TAIL_SEG = seg_of_pos(SPLIT_N - 1, SPLIT_N, BIG_EN != 0);
  localparam logic [SPLIT_N-1:0] TAIL_MASK = SPLIT_N'(1) << TAIL_SEG;

  logic [SPLIT_N-1:0] nz;

  // An all-zero final word still emits its tail slice to close the packet.
  always_comb begin
    nz = '0;
    for (int s = 0; s < SPLIT_N; s++) nz[s] = |din_w[s];
    cap_mask = nz | (((nz == '0) && bus.last_i) ? TAIL_MASK : '0);
  end
  assign absorb = (nz == '0) && !bus.last_i;
`else
  assign cap_mask = '1;
  assign absorb   = 1'b0;
`endif

  bridge_split_pick #(.SPLIT_N(SPLIT_N), .BIG_EN(BIG_EN), .IDX_W(IDX_W)) u_pick (
    .cap_mask  (cap_mask),
    .pend      (pend_q),
    .cur       (idx_q),
    .first_idx (first_idx),
    .next_idx  (next_idx),
    .is_final  (is_final)
  );

  assign capture = bus.rdy_o && bus.vld_i;
  assign load    = capture && !absorb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= Empty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Empty:   if (load) state_d = Split;
      Split:   if (bus.rdy_i && is_final) state_d = load ? Split : Empty;
      default: state_d = Empty;
    endcase
  end

  always_comb begin
    accept     = (state_q == Empty) || (bus.rdy_i && is_final);
    bus.rdy_o  = accept && !rst;
    bus.vld_o  = (state_q == Split);
    bus.last_o = (state_q == Split) && last_q && is_final;
    bus.dout   = word_q[idx_q];
  end

  // Capture on load; otherwise retire the current slice and step to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      last_q <= 1'b0;
      pend_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= din_w;
      last_q <= bus.last_i;
      pend_q <= cap_mask;
      idx_q  <= first_idx;
    end else if ((state_q == Split) && bus.rdy_i && !is_final) begin
      pend_q[idx_q] <= 1'b0;
      idx_q         <= next_idx;
    end
  end

endmodule
